// File: rtl/ternary_neuron_acc.sv
// ternary_neuron_acc: accumulates (pos_cnt - neg_cnt) from popcount11 units over
// a multi-beat frame, saturating to ACC_W signed bits, then thresholds the final
// sum into a ternary activation held behind a valid/ready handshake.
module ternary_neuron_acc #(
    parameter int ACC_W     = 8,   // signed accumulator width, 6..16
    parameter int MAX_BEATS = 8    // forced frame close after this many beats, 1..255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [3:0]              pos_cnt,
    input  logic [3:0]              neg_cnt,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_act,
    output logic [ACC_W-1:0]        out_sum,
    output logic                    out_sat,
    output logic                    out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [8:0] MAX_CNT = 9'(MAX_BEATS);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [7:0]              beat_cnt;
    logic signed [ACC_W-1:0] thr_hi_q, thr_lo_q;
    logic                    sat_q;

    logic                    beat_fire, res_fire;
    logic signed [4:0]       delta;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W:0]   sum_ext;
    logic                    clamp;
    logic signed [ACC_W-1:0] sum_sat;
    logic [8:0]              cnt_nxt;
    logic                    hit_max, closes;
    logic signed [ACC_W-1:0] thr_hi_eff, thr_lo_eff;
    logic                    frame_sat;
    logic [1:0]              act_nxt;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign beat_fire = in_valid & in_ready;
    assign res_fire  = out_valid & out_ready;

    // Saturating add of this beat's delta, frame-close detection and threshold decision.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        delta      = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
        // The first beat of a frame starts from zero and uses the live thresholds,
        // which are only latched on that same edge.
        acc_base   = (state == IDLE) ? '0 : acc;
        thr_hi_eff = (state == IDLE) ? thr_hi : thr_hi_q;
        thr_lo_eff = (state == IDLE) ? thr_lo : thr_lo_q;
        sum_ext    = {acc_base[ACC_W-1], acc_base} + {{(ACC_W-4){delta[4]}}, delta};
        // One extra bit is enough since |delta| <= 15 is far below the ACC_W range;
        // disagreement of the top two bits means the true sum left the ACC_W range.
        clamp      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        sum_sat    = sum_ext[ACC_W-1:0];
        if (clamp) begin
            sum_sat = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        cnt_nxt    = ((state == IDLE) ? 9'd0 : {1'b0, beat_cnt}) + 9'd1;
        hit_max    = (cnt_nxt == MAX_CNT);
        closes     = in_last | hit_max;
        frame_sat  = ((state == IDLE) ? 1'b0 : sat_q) | clamp;
        // +1 wins when the thresholds overlap.
        act_nxt    = 2'b00;
        if (sum_sat >= thr_hi_eff) begin
            act_nxt = 2'b01;
        end else if (sum_sat <= thr_lo_eff) begin
            act_nxt = 2'b11;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (beat_fire) state_nxt = closes ? HOLD : ACC;
            ACC:  if (beat_fire && closes) state_nxt = HOLD;
            HOLD: if (res_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers
            // update together from pre-edge values.
            state <= state_nxt;
        end
    end

    // Accumulator, frame bookkeeping and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
            thr_hi_q <= '0;
            thr_lo_q <= '0;
            sat_q    <= 1'b0;
            out_act  <= 2'b00;
            out_sum  <= '0;
            out_sat  <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (beat_fire) begin
            acc      <= sum_sat;
            beat_cnt <= cnt_nxt[7:0];
            sat_q    <= frame_sat;
            if (state == IDLE) begin
                thr_hi_q <= thr_hi;
                thr_lo_q <= thr_lo;
            end
            if (closes) begin
                out_sum <= sum_sat;
                out_act <= act_nxt;
                out_sat <= frame_sat;
                out_ovf <= hit_max & ~in_last;
            end
        end else if (res_fire) begin
            // Result taken: clear the frame, keep out_* visible for observers.
            acc      <= '0;
            beat_cnt <= '0;
            sat_q    <= 1'b0;
        end
    end

endmodule
